// File: rtl/chunk_feed_pkg.sv
// Shared types and constants for the chunk block feeder.
package chunk_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } feed_state_t;

    localparam int BLOCK_WORDS = 16;
    localparam int BLOCK_BYTES = 64;
    localparam int BYTE_CNT_W  = 11;
    localparam int MAX_BYTES   = 1024;

    // Keeps only the bytes of the final word that belong to the chunk.
    function automatic logic [31:0] last_word_mask(input logic [1:0] byte_num_lsb);
        logic [31:0] mask_s;
        case (byte_num_lsb)
            2'd1:    mask_s = 32'h0000_00ff;
            2'd2:    mask_s = 32'h0000_ffff;
            2'd3:    mask_s = 32'h00ff_ffff;
            default: mask_s = 32'hffff_ffff;
        endcase
        return mask_s;
    endfunction

endpackage

// File: rtl/chunk_block_feeder_buffer.sv
// One 16-word message block register file with word writes, clear and full flag.
module block_buffer
    import chunk_feed_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Clr,
    input  logic         Wr_En,
    input  logic [3:0]   Wr_Idx,
    input  logic [31:0]  Wr_Data,
    input  logic         Wr_Last,
    input  logic         Mark_Full,
    output logic [511:0] Msg,
    output logic         Full
);

    logic [31:0] mem_r [BLOCK_WORDS];
    logic        full_r;

    // Word storage and full flag; clear takes priority over writes.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            full_r <= 1'b0;
        end else if (Clr) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            full_r <= 1'b0;
        end else begin
            if (Wr_En) begin
                mem_r[Wr_Idx] <= Wr_Data;
            end
            if ((Wr_En && ((Wr_Idx == 4'd15) || Wr_Last)) || Mark_Full) begin
                full_r <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_msg
        assign Msg[g*32 +: 32] = mem_r[g];
    end

    assign Full = full_r;

endmodule

// File: rtl/chunk_block_feeder.sv
// Assembles a 32-bit word stream into 64-byte blocks in a ping-pong buffer
// and presents them one at a time to the chunk hasher.
module chunk_block_feeder
    import chunk_feed_pkg::*;
(
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start_I,
    input  logic [10:0]  Byte_num_I,
    input  logic [31:0]  Data_I,
    input  logic         Data_Vld_I,
    output logic         Data_Rdy_O,
    input  logic         Next_I,
    output logic         Update_O,
    output logic         Clear_O,
    output logic [511:0] Msg_O,
    output logic [10:0]  Byte_num_O,
    output logic         Blk_Vld_O,
    output logic         Busy_O,
    output logic         Underrun_O
);

    feed_state_t  state_r;
    logic         rd_sel_r;
    logic         wr_sel_r;
    logic         pending_r;
    logic         update_r;
    logic         clear_r;
    logic         blk_vld_r;
    logic         busy_r;
    logic         underrun_r;
    logic [10:0]  byte_num_r;
    logic [10:0]  words_total_r;
    logic [10:0]  words_rcvd_r;
    logic [10:0]  blocks_total_r;
    logic [10:0]  blk_idx_r;

    logic [10:0]  byte_num_clamp_s;
    logic [10:0]  words_total_s;
    logic [10:0]  blk_sum_s;
    logic [10:0]  blocks_total_s;
    logic         full0_s;
    logic         full1_s;
    logic [511:0] msg0_s;
    logic [511:0] msg1_s;
    logic         fill_full_s;
    logic         data_rdy_s;
    logic         hs_s;
    logic         last_word_s;
    logic [31:0]  wr_data_s;
    logic         complete_s;
    logic         empty_chunk_s;
    logic         first_done_s;
    logic         in_run_s;
    logic         last_blk_s;
    logic         pend_s;
    logic         next_ready_s;
    logic         finish_s;
    logic         swap_s;
    logic         starve_s;

    assign byte_num_clamp_s = (Byte_num_I > 11'd1024) ? 11'd1024 : Byte_num_I;
    assign words_total_s    = (byte_num_clamp_s + 11'd3) >> 2;
    assign blk_sum_s        = (words_total_s + 11'd15) >> 4;
    assign blocks_total_s   = (blk_sum_s == 11'd0) ? 11'd1 : blk_sum_s;

    assign fill_full_s = wr_sel_r ? full1_s : full0_s;
    assign data_rdy_s  = (state_r != IDLE) && !fill_full_s && (words_rcvd_r < words_total_r);
    assign hs_s        = data_rdy_s && Data_Vld_I && !Start_I;
    assign last_word_s = ((words_rcvd_r + 11'd1) == words_total_r);
    assign wr_data_s   = last_word_s ? (Data_I & last_word_mask(byte_num_r[1:0])) : Data_I;
    // Word index inside a block is simply the low bits of the running word count.
    assign complete_s  = hs_s && ((words_rcvd_r[3:0] == 4'd15) || last_word_s);

    assign empty_chunk_s = (state_r == FIRST) && (words_total_r == 11'd0) && !Start_I;
    assign first_done_s  = (state_r == FIRST) && !Start_I && (complete_s || (words_total_r == 11'd0));
    assign in_run_s      = (state_r == RUN) && !Start_I;
    assign last_blk_s    = (blk_idx_r == (blocks_total_r - 11'd1));
    assign pend_s        = pending_r || Next_I;
    // A word completing the fill buffer in the same cycle counts as full.
    assign next_ready_s  = fill_full_s || complete_s;
    assign finish_s      = in_run_s && Next_I && last_blk_s;
    assign swap_s        = in_run_s && !last_blk_s && pend_s && next_ready_s;
    assign starve_s      = in_run_s && !last_blk_s && pend_s && !next_ready_s;

    block_buffer u_buf0 (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clr       (Start_I || (swap_s && !rd_sel_r)),
        .Wr_En     (hs_s && !wr_sel_r),
        .Wr_Idx    (words_rcvd_r[3:0]),
        .Wr_Data   (wr_data_s),
        .Wr_Last   (last_word_s),
        .Mark_Full (empty_chunk_s),
        .Msg       (msg0_s),
        .Full      (full0_s)
    );

    block_buffer u_buf1 (
        .Clk       (Clk),
        .Rst       (Rst),
        .Clr       (Start_I || (swap_s && rd_sel_r)),
        .Wr_En     (hs_s && wr_sel_r),
        .Wr_Idx    (words_rcvd_r[3:0]),
        .Wr_Data   (wr_data_s),
        .Wr_Last   (last_word_s),
        .Mark_Full (1'b0),
        .Msg       (msg1_s),
        .Full      (full1_s)
    );

    // Control FSM with counters and registered status outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r        <= IDLE;
            rd_sel_r       <= 1'b0;
            wr_sel_r       <= 1'b0;
            pending_r      <= 1'b0;
            update_r       <= 1'b0;
            clear_r        <= 1'b0;
            blk_vld_r      <= 1'b0;
            busy_r         <= 1'b0;
            underrun_r     <= 1'b0;
            byte_num_r     <= 11'd0;
            words_total_r  <= 11'd0;
            words_rcvd_r   <= 11'd0;
            blocks_total_r <= 11'd0;
            blk_idx_r      <= 11'd0;
        end else begin
            update_r <= 1'b0;
            clear_r  <= 1'b0;
            if (Start_I) begin
                clear_r        <= (state_r != IDLE);
                state_r        <= FIRST;
                byte_num_r     <= byte_num_clamp_s;
                words_total_r  <= words_total_s;
                blocks_total_r <= blocks_total_s;
                words_rcvd_r   <= 11'd0;
                blk_idx_r      <= 11'd0;
                rd_sel_r       <= 1'b0;
                wr_sel_r       <= 1'b0;
                pending_r      <= 1'b0;
                blk_vld_r      <= 1'b0;
                busy_r         <= 1'b1;
                underrun_r     <= 1'b0;
            end else begin
                if (hs_s) begin
                    words_rcvd_r <= words_rcvd_r + 11'd1;
                end
                case (state_r)
                    IDLE: begin
                        busy_r <= 1'b0;
                    end
                    FIRST: begin
                        if (first_done_s) begin
                            state_r   <= RUN;
                            update_r  <= 1'b1;
                            blk_vld_r <= 1'b1;
                            wr_sel_r  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (finish_s) begin
                            state_r   <= IDLE;
                            blk_vld_r <= 1'b0;
                            busy_r    <= 1'b0;
                        end else if (swap_s) begin
                            rd_sel_r  <= wr_sel_r;
                            wr_sel_r  <= rd_sel_r;
                            pending_r <= 1'b0;
                            blk_vld_r <= 1'b1;
                            blk_idx_r <= blk_idx_r + 11'd1;
                        end else if (starve_s) begin
                            pending_r  <= 1'b1;
                            blk_vld_r  <= 1'b0;
                            underrun_r <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign Data_Rdy_O = data_rdy_s;
    assign Msg_O      = rd_sel_r ? msg1_s : msg0_s;
    assign Update_O   = update_r;
    assign Clear_O    = clear_r;
    assign Byte_num_O = byte_num_r;
    assign Blk_Vld_O  = blk_vld_r;
    assign Busy_O     = busy_r;
    assign Underrun_O = underrun_r;

endmodule

// File: doc/chunk_block_feeder.md
Name: chunk_block_feeder

Overview:
Upstream feeder for the chunk hashing stage. Collects a 32-bit little-endian word stream for one chunk of up to 1024 bytes. Assembles the words into 64-byte message blocks held in a two-entry ping-pong buffer. Presents one block at a time to the hasher and advances to the next block on the hasher's next-block request, zero-padding the final partial block.

Parameters:
MAX_BYTES, 1024, maximum chunk length in bytes; sets the byte-count width as $clog2(MAX_BYTES)+1 = 11.
BLOCK_WORDS, 16, 32-bit words per message block (64 bytes).

Ports:
Clk  in  1  clock
Rst  in  1  asynchronous reset, active high
Start_I  in  1  one-cycle pulse; latches Byte_num_I and begins a new chunk (aborts any chunk in progress)
Byte_num_I  in  11  chunk length in bytes, 0..1024
Data_I  in  32  input word; byte 0 of the word is bits [7:0]
Data_Vld_I  in  1  Data_I valid
Data_Rdy_O  out  1  feeder accepts Data_I this cycle
Next_I  in  1  hasher has consumed the presented block
Update_O  out  1  one-cycle pulse; first block of the chunk is stable on Msg_O
Clear_O  out  1  one-cycle pulse when Start_I aborts a busy chunk
Msg_O  out  16x32  presented block; word 0 = bytes 0..3
Byte_num_O  out  11  latched chunk length
Blk_Vld_O  out  1  Msg_O holds a complete block
Busy_O  out  1  chunk in progress
Underrun_O  out  1  sticky; Next_I arrived while the following block was not yet full

Behaviour:
- Reset values: all outputs 0, both buffers cleared, state IDLE.
- Reset is asynchronous. Asserting Rst mid-chunk discards all buffered data. After release the block sits in IDLE.
- Derived counts, latched at Start_I:
  - words_total = ceil(Byte_num/4)
  - blocks_total = max(1, ceil(Byte_num/64)); Byte_num=0 gives one all-zero block.
- Input handshake: a word transfers when Data_Vld_I && Data_Rdy_O.
  - Data_Rdy_O = (state != IDLE) && (fill buffer not full) && (words_received < words_total).
- Last-word masking: in the final word, bytes at index >= Byte_num mod 4 are forced to 0 when Byte_num mod 4 != 0.
- Block completion: a block is complete after 16 words, or when the last word of the chunk is written. Any unwritten words in a final partial block are 0 (buffers are cleared on allocation).
- State machine:
  - IDLE: Start_I -> FIRST.
  - FIRST: fills buffer 0. On the cycle it completes, the buffer becomes full. The next cycle drives Update_O=1 and Blk_Vld_O=1, and the state moves to RUN.
  - RUN:
    - Filling continues into the other buffer while the presented block is held.
    - Next_I sets a pending flag.
    - When pending && other buffer full: swap the read select, clear the old buffer, clear pending. Msg_O changes on the cycle after the swap condition.
    - If pending when the swap cannot occur: Blk_Vld_O=0 and Underrun_O=1 (sticky until Start_I or Rst). The swap occurs once the buffer fills.
    - Next_I on the last block: Blk_Vld_O=0, state -> IDLE. Msg_O holds its last value.
- Simultaneous events:
  - Next_I in the same cycle as the word that completes the other buffer: counts as full, swap with no underrun.
  - Start_I while Busy_O=1: Clear_O pulses next cycle, buffers and counters reset, state -> FIRST with the new length. Start_I wins over Next_I and data in the same cycle.
  - Start_I in IDLE: no Clear_O.
- Latency: the Update_O pulse occurs 1 cycle after the 16th (or last) word handshake. Busy_O=1 from the cycle after Start_I until return to IDLE.
- Widths: byte and word counters are 11 bits and saturate; no wrap. Byte_num_I > 1024 is clamped to 1024.

Decomposition:
- Package chunk_feed_pkg:
  - state enum {IDLE, FIRST, RUN}
  - BLOCK_WORDS=16, BLOCK_BYTES=64, BYTE_CNT_W=11
  - function last_word_mask(byte_num)
- Sub-module block_buffer: 16x32 register file with word-indexed write enable, synchronous clear and full flag. Instantiated twice.

Test Plan:
- Byte_num=64, 16 words 0x03020100.. streamed back-to-back -> Update_O 1 cycle after the 16th handshake; Msg_O[0]=0x03020100; one Next_I -> Blk_Vld_O=0, Busy_O=0.
- Byte_num=130 (3 blocks, 33 words) -> block 2 word 0 holds bytes 128..129 with upper 16 bits 0, words 1..15 = 0; exactly 3 Next_I return to IDLE.
- Byte_num=0 -> Data_Rdy_O never 1; Update_O pulses with Msg_O all zero.
- Byte_num=128, Next_I after block 0 while block 1 has 10 words -> Underrun_O=1, Blk_Vld_O=0 until the 16th word; swap happens the following cycle.
- Byte_num=1024, Start_I reissued mid-block 5 with Byte_num=4 -> Clear_O pulse, Underrun_O cleared, next Update_O shows only word 0 of the new data.
- Rst asserted during RUN -> all outputs 0 immediately (asynchronous); no Update_O after release without Start_I.
